// File: rtl/adc_frame_sequencer.sv
`timescale 1ns / 1ps
// Frame sequencer for the SPI ADC front end. It arms a 64-sample capture (one-shot or
// periodic), detects buffer-full, and drains the buffer into a valid/ready stream.
module adc_frame_sequencer #(
    parameter int unsigned N_SAMPLES = 64,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned PERIOD_W  = 24,
    parameter int unsigned TMO_W     = 20
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ctrl_en_i,
    input  logic                start_i,
    input  logic                continuous_i,
    input  logic [PERIOD_W-1:0] frame_period_i,
    input  logic [TMO_W-1:0]    timeout_limit_i,
    input  logic [15:0]         clk_div_cfg_i,
    input  logic                err_clr_i,
    output logic                adc_enable_o,
    output logic [15:0]         adc_clk_div_o,
    input  logic                adc_samples_valid_i,
    output logic [ADDR_W-1:0]   adc_sample_addr_o,
    input  logic [15:0]         adc_sample_data_i,
    output logic [15:0]         m_data_o,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic                m_last_o,
    output logic                busy_o,
    output logic                frame_done_o,
    output logic [15:0]         frame_cnt_o,
    output logic                timeout_err_o,
    output logic                overrun_o
);
    typedef enum logic [1:0] {IDLE, ACQ, RD, OUT} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

    state_t              state_q, state_d;
    logic                en_q, en_d;
    logic [15:0]         div_q, div_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                done_q, done_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                tmo_err_q, tmo_err_d;
    logic                ovr_q, ovr_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
    logic                sv_q, sv_edge_q;
    logic                per_expire, trigger, tmo_set, ovr_set;

    assign per_expire = continuous_i && (frame_period_i != '0)
                        && (per_cnt_q == frame_period_i - PERIOD_W'(1));
    assign trigger    = ctrl_en_i && (start_i || per_expire
                        || (continuous_i && (frame_period_i == '0)));

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        div_d     = div_q;
        addr_d    = addr_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        per_cnt_d = per_cnt_q;
        tmo_set   = 1'b0;
        ovr_set   = 1'b0;

        // The period timer free-runs in continuous mode and wraps on expiry.
        if (continuous_i) begin
            per_cnt_d = per_expire ? '0 : per_cnt_q + PERIOD_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d   = ACQ;
                    en_d      = 1'b1;
                    div_d     = clk_div_cfg_i;
                    tmo_cnt_d = '0;
                    per_cnt_d = '0;
                end
            end
            ACQ: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (sv_edge_q) begin
                    en_d    = 1'b0;
                    addr_d  = '0;
                    state_d = RD;
                end else if ((timeout_limit_i != '0)
                             && (tmo_cnt_q == timeout_limit_i - TMO_W'(1))) begin
                    tmo_set = 1'b1;
                    en_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            RD: begin
                data_d  = adc_sample_data_i;
                valid_d = 1'b1;
                last_d  = (addr_q == LAST_ADDR);
                state_d = OUT;
            end
            OUT: begin
                if (m_ready_i) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        done_d  = 1'b1;
                        cnt_d   = cnt_q + 16'd1;
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (per_expire && (state_q != IDLE)) begin
            ovr_set = 1'b1;
        end

        // Disable overrides everything: abandon the frame without counting it.
        if (!ctrl_en_i) begin
            state_d = IDLE;
            en_d    = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            addr_d  = '0;
            done_d  = 1'b0;
            cnt_d   = cnt_q;
        end

        tmo_err_d = tmo_set | (tmo_err_q & ~err_clr_i);
        ovr_d     = ovr_set | (ovr_q & ~err_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            div_q     <= 16'd4;
            addr_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            tmo_err_q <= 1'b0;
            ovr_q     <= 1'b0;
            tmo_cnt_q <= '0;
            per_cnt_q <= '0;
            sv_q      <= 1'b0;
            sv_edge_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            div_q     <= div_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            tmo_err_q <= tmo_err_d;
            ovr_q     <= ovr_d;
            tmo_cnt_q <= tmo_cnt_d;
            per_cnt_q <= per_cnt_d;
            sv_q      <= adc_samples_valid_i;
            sv_edge_q <= adc_samples_valid_i & ~sv_q;
        end
    end

    assign adc_enable_o      = en_q;
    assign adc_clk_div_o     = div_q;
    assign adc_sample_addr_o = addr_q;
    assign m_data_o          = data_q;
    assign m_valid_o         = valid_q;
    assign m_last_o          = last_q;
    assign busy_o            = (state_q != IDLE);
    assign frame_done_o      = done_q;
    assign frame_cnt_o       = cnt_q;
    assign timeout_err_o     = tmo_err_q;
    assign overrun_o         = ovr_q;

endmodule

// File: tb/tb_adc_frame_sequencer.sv
`timescale 1ns / 1ps
// Bench for adc_frame_sequencer: ADC buffer model, stream scoreboard, scenario table
// and hand-written sequences for backpressure, abort and continuous mode.
module tb_adc_frame_sequencer;
    localparam int N = 64;

    logic        clk = 1'b0;
    logic        rst, ctrl_en, start, continuous, err_clr, m_ready;
    logic [23:0] frame_period;
    logic [19:0] timeout_limit;
    logic [15:0] clk_div_cfg;
    logic        adc_enable, adc_samples_valid = 1'b0;
    logic [15:0] adc_clk_div, adc_sample_data, m_data, frame_cnt;
    logic [5:0]  adc_sample_addr;
    logic        m_valid, m_last, busy, frame_done, timeout_err, overrun;

    always #5 clk = ~clk;

    adc_frame_sequencer #(.N_SAMPLES(64), .ADDR_W(6), .PERIOD_W(24), .TMO_W(20)) dut (
        .clk_i(clk), .rst_i(rst), .ctrl_en_i(ctrl_en), .start_i(start),
        .continuous_i(continuous), .frame_period_i(frame_period),
        .timeout_limit_i(timeout_limit), .clk_div_cfg_i(clk_div_cfg), .err_clr_i(err_clr),
        .adc_enable_o(adc_enable), .adc_clk_div_o(adc_clk_div),
        .adc_samples_valid_i(adc_samples_valid), .adc_sample_addr_o(adc_sample_addr),
        .adc_sample_data_i(adc_sample_data), .m_data_o(m_data), .m_valid_o(m_valid),
        .m_ready_i(m_ready), .m_last_o(m_last), .busy_o(busy), .frame_done_o(frame_done),
        .frame_cnt_o(frame_cnt), .timeout_err_o(timeout_err), .overrun_o(overrun)
    );

    int n_checks = 0, n_errors = 0;
    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // ADC model: enable rising clears valid, buffer fills after a random delay.
    logic [15:0] adc_mem [N];
    bit          adc_dead = 1'b0, fixed_pat = 1'b0;
    int          adc_delay = 5, adc_wait = 0;
    logic        en_prev = 1'b0;
    logic [15:0] pv;
    always @(posedge clk) begin
        en_prev <= adc_enable;
        if (adc_enable && !en_prev) begin
            adc_samples_valid <= 1'b0;
            adc_wait          <= 0;
            adc_delay         <= $urandom_range(30, 3);
        end else if (adc_enable && !adc_dead && !adc_samples_valid) begin
            if (adc_wait >= adc_delay) begin
                for (int i = 0; i < N; i++) begin
                    pv = fixed_pat ? 16'(2048 + 100 * (i % 16)) : 16'($urandom);
                    adc_mem[i] <= pv;
                end
                adc_samples_valid <= 1'b1;
            end
            adc_wait <= adc_wait + 1;
        end
    end
    assign adc_sample_data = adc_mem[adc_sample_addr];

    int rdy_mode = 1;  // 0 = hold low, 1 = always high, 2 = random
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = 1'($urandom_range(1, 0));
            endcase
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: a captured buffer must appear on the stream in address order.
    logic [15:0] exp_q [$];
    int   beat_idx = 0, frames_model = 0, done_seen = 0, beats_total = 0, mvalid_cycles = 0;
    int   en_rise_cyc = 0, en_rise_cnt = 0, vld_rise_cyc = 0, tmo_rise_cyc = 0, ovr_rise_cyc = 0;
    int   last_hs_edge = -10;
    logic p_en = 0, p_vld = 0, p_tmo = 0, p_ovr = 0, p_stall = 0, p_ctrl = 1, p_last = 0;
    logic [15:0] p_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (adc_enable && !p_en) begin
                en_rise_cyc = cyc;
                en_rise_cnt++;
            end
            if (adc_samples_valid && !p_vld) begin
                vld_rise_cyc = cyc;
                for (int i = 0; i < N; i++) exp_q.push_back(adc_mem[i]);
            end
            if (!adc_enable && p_en && adc_samples_valid && p_ctrl)
                check("enable_fall_latency", cyc - vld_rise_cyc, 2);
            if (timeout_err && !p_tmo) tmo_rise_cyc = cyc;
            if (overrun && !p_ovr) ovr_rise_cyc = cyc;
            if (m_valid) mvalid_cycles++;
            if (p_stall && p_ctrl) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, p_data);
                check("stall_last", m_last, p_last);
            end
            if (frame_done) begin
                done_seen++;
                check("frame_done_timing", cyc, last_hs_edge);
                check("frame_cnt_at_done", frame_cnt, frames_model & 16'hFFFF);
            end
            if (!ctrl_en) begin
                exp_q.delete();
                beat_idx = 0;
            end else if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
                else check("beat_data", m_data, exp_q.pop_front());
                check("beat_last", m_last, beat_idx == N - 1);
                beat_idx++;
                beats_total++;
                if (beat_idx == N) begin
                    beat_idx     = 0;
                    frames_model++;
                    last_hs_edge = cyc + 1;
                end
            end
        end
        p_stall = m_valid && !m_ready && !rst;
        p_data = m_data; p_last = m_last; p_en = adc_enable; p_vld = adc_samples_valid;
        p_tmo = timeout_err; p_ovr = overrun; p_ctrl = ctrl_en;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (busy && n < limit) begin tick(1); n++; end
        check({name, "_idle"}, busy, 0);
    endtask

    task automatic wait_rise(input string name, input int limit);
        int n = 0;
        int c0 = en_rise_cnt;
        while (en_rise_cnt == c0 && n < limit) begin tick(1); n++; end
        check({name, "_rise"}, en_rise_cnt != c0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_adc_enable"}, adc_enable, 0);
        check({tag, "_adc_clk_div"}, adc_clk_div, 4);
        check({tag, "_addr"}, adc_sample_addr, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    typedef struct {
        string       name;
        logic [15:0] div;
        int          rdy;
        int          tmo_lim;
        bit          dead;
        bit          fixed;
        logic        exp_tmo;
        int          exp_frames;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int   exp_fc, b0, mv0, d0, n, c1, c2, c3, r0;
        string nm;

        vecs[0] = '{"single",  16'd4,      1, 0,    1'b0, 1'b1, 1'b0, 1};
        vecs[1] = '{"randrdy", 16'd7,      2, 5000, 1'b0, 1'b0, 1'b0, 1};
        vecs[2] = '{"timeout", 16'd9,      1, 1000, 1'b1, 1'b0, 1'b1, 0};
        vecs[3] = '{"maxdiv",  16'hFFFF,   2, 0,    1'b0, 1'b0, 1'b0, 1};

        rst = 1'b1; ctrl_en = 1'b0; start = 1'b0; continuous = 1'b0; err_clr = 1'b0;
        frame_period = '0; timeout_limit = '0; clk_div_cfg = 16'd4;
        exp_fc = 0;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        ctrl_en = 1'b1;
        tick(100);
        check("idle_no_enable", en_rise_cnt, 0);
        check_reset_outputs("idle");

        for (int v = 0; v < 4; v++) begin
            nm            = vecs[v].name;
            clk_div_cfg   = vecs[v].div;
            rdy_mode      = vecs[v].rdy;
            timeout_limit = 20'(vecs[v].tmo_lim);
            adc_dead      = vecs[v].dead;
            fixed_pat     = vecs[v].fixed;
            b0 = beats_total; mv0 = mvalid_cycles; d0 = done_seen;
            pulse_start();
            check({nm, "_enable_1cyc"}, adc_enable, 1);
            check({nm, "_busy"}, busy, 1);
            wait_idle(nm, 3000);
            tick(2);
            exp_fc += vecs[v].exp_frames;
            check({nm, "_beats"}, beats_total - b0, N * vecs[v].exp_frames);
            check({nm, "_frame_done_cnt"}, done_seen - d0, vecs[v].exp_frames);
            check({nm, "_frame_cnt"}, frame_cnt, exp_fc);
            check({nm, "_timeout_err"}, timeout_err, vecs[v].exp_tmo);
            check({nm, "_clk_div"}, adc_clk_div, vecs[v].div);
            check({nm, "_queue_empty"}, exp_q.size(), 0);
            if (vecs[v].exp_tmo) begin
                check({nm, "_tmo_cycles"}, tmo_rise_cyc - en_rise_cyc, vecs[v].tmo_lim);
                check({nm, "_no_m_valid"}, mvalid_cycles - mv0, 0);
                check({nm, "_enable_off"}, adc_enable, 0);
                err_clr = 1'b1;
                tick(1);
                err_clr = 1'b0;
                check({nm, "_err_clr"}, timeout_err, 0);
            end
        end
        adc_dead = 1'b0;
        timeout_limit = '0;

        // Backpressure: 50-cycle stall mid-frame, plus a start pulse while busy.
        rdy_mode = 2; fixed_pat = 1'b0; b0 = beats_total; r0 = en_rise_cnt;
        pulse_start();
        n = 0;
        while (beat_idx < 20 && n < 2000) begin tick(1); n++; end
        check("bp_reach_beat20", beat_idx >= 20, 1);
        rdy_mode = 0;
        pulse_start();
        tick(49);
        rdy_mode = 2;
        wait_idle("bp", 3000);
        tick(2);
        exp_fc++;
        check("bp_beats", beats_total - b0, N);
        check("bp_frame_cnt", frame_cnt, exp_fc);
        check("bp_single_acq", en_rise_cnt - r0, 1);
        check("bp_no_overrun", overrun, 0);

        // Abort at drain beat 10.
        rdy_mode = 1; d0 = done_seen;
        pulse_start();
        n = 0;
        while (beat_idx < 10 && n < 2000) begin tick(1); n++; end
        check("abort_reach_beat10", beat_idx >= 10, 1);
        ctrl_en = 1'b0;
        tick(1);
        check("abort_m_valid", m_valid, 0);
        check("abort_adc_enable", adc_enable, 0);
        check("abort_busy", busy, 0);
        check("abort_addr", adc_sample_addr, 0);
        check("abort_frame_cnt", frame_cnt, exp_fc);
        tick(2);
        check("abort_no_done", done_seen - d0, 0);
        ctrl_en = 1'b1;

        // Continuous, 20000-cycle period; divider change mid-frame.
        clk_div_cfg = 16'd10; frame_period = 24'd20000; continuous = 1'b1;
        pulse_start();
        tick(1);
        c1 = en_rise_cyc;
        wait_rise("cont2", 20100);
        c2 = en_rise_cyc;
        check("cont_period1", c2 - c1, 20000);
        check("cont_cnt1", frame_cnt, exp_fc + 1);
        tick(5);
        clk_div_cfg = 16'd33;
        tick(1);
        check("cont_div_hold", adc_clk_div, 10);
        wait_rise("cont3", 20100);
        c3 = en_rise_cyc;
        check("cont_period2", c3 - c2, 20000);
        check("cont_cnt2", frame_cnt, exp_fc + 2);
        check("cont_div_new", adc_clk_div, 33);
        continuous = 1'b0;
        wait_idle("cont_end", 3000);
        tick(2);
        exp_fc += 3;
        check("cont_cnt3", frame_cnt, exp_fc);
        check("cont_no_overrun", overrun, 0);

        // Overrun: short period with the stream stalled.
        rdy_mode = 0; frame_period = 24'd300; r0 = en_rise_cnt;
        continuous = 1'b1;
        pulse_start();
        tick(1);
        c1 = en_rise_cyc;
        n = 0;
        while (!overrun && n < 400) begin tick(1); n++; end
        tick(1);
        check("ovr_set", overrun, 1);
        check("ovr_cycles", ovr_rise_cyc - c1, 300);
        check("ovr_trigger_dropped", en_rise_cnt - r0, 1);
        continuous = 1'b0;
        ctrl_en = 1'b0;
        tick(2);
        ctrl_en = 1'b1;
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("ovr_err_clr", overrun, 0);
        check("ovr_frame_cnt", frame_cnt, exp_fc);
        check("final_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
